// File: rtl/pipeline_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipeline_rr_arbiter                                                      |
// | Round-robin N:1 valid/ready arbiter with packet locking and one          |
// | registered output stage.                                                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module pipeline_rr_arbiter #(
   parameter int N  = 2,
   parameter int DW = 256,
   parameter int GW = (N > 1 ? $clog2(N) : 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    i_valid,
   output logic [N-1:0]    i_ready,
   input  logic [N*DW-1:0] i_data,
   input  logic [N-1:0]    i_last,
   output logic            o_valid,
   input  logic            o_ready,
   output logic [DW-1:0]   o_data,
   output logic            o_last,
   output logic [GW-1:0]   o_grant
);

   localparam logic [GW:0]   c_n      = (GW+1)'(N);
   localparam logic [GW-1:0] c_last_i = GW'(N-1);

   logic            r_valid;
   logic [DW-1:0]   r_data;
   logic            r_last;
   logic [GW-1:0]   r_grant;
   logic [GW-1:0]   r_ptr;
   logic            r_lock;
   logic [GW-1:0]   r_lock_idx;

   logic            w_slot_free;
   logic            w_has_gnt;
   logic [GW-1:0]   w_gnt;
   logic [GW:0]     w_sum;
   logic            w_accept;
   logic [GW-1:0]   w_ptr_next;

   assign w_slot_free = !r_valid || o_ready;

   // A locked packet owns the channel even when its requester idles.
   always_comb begin
      w_has_gnt = 1'b0;
      w_gnt     = '0;
      w_sum     = '0;
      if (r_lock) begin
         w_has_gnt = i_valid[r_lock_idx];
         w_gnt     = r_lock_idx;
      end else begin
         for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (GW+1)'(k);
            if (w_sum >= c_n) begin
               w_sum = w_sum - c_n;
            end
            if (!w_has_gnt && i_valid[w_sum[GW-1:0]]) begin
               w_has_gnt = 1'b1;
               w_gnt     = w_sum[GW-1:0];
            end
         end
      end
   end

   generate
      for (genvar g = 0; g < N; g++) begin : g_ready
         assign i_ready[g] = w_has_gnt && w_slot_free && (w_gnt == GW'(g));
      end
   endgenerate

   assign w_accept   = w_has_gnt && w_slot_free;
   assign w_ptr_next = (w_gnt == c_last_i) ? '0 : w_gnt + GW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_last     <= 1'b0;
         r_grant    <= '0;
         r_ptr      <= '0;
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
      end else begin
         if (w_accept) begin
            r_valid <= 1'b1;
            r_data  <= i_data[w_gnt*DW +: DW];
            r_last  <= i_last[w_gnt];
            r_grant <= w_gnt;
            if (i_last[w_gnt]) begin
               r_lock <= 1'b0;
               r_ptr  <= w_ptr_next;
            end else begin
               r_lock     <= 1'b1;
               r_lock_idx <= w_gnt;
            end
         end else if (o_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;
   assign o_last  = r_last;
   assign o_grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipeline_rr_arbiter                                                   |
// | Directed self-checking bench for pipeline_rr_arbiter (N=4, DW=16).       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_pipeline_rr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int GW = 2;

   logic            clk;
   logic            rst_n;
   logic [N-1:0]    i_valid;
   logic [N-1:0]    i_ready;
   logic [N*DW-1:0] i_data;
   logic [N-1:0]    i_last;
   logic            o_valid;
   logic            o_ready;
   logic [DW-1:0]   o_data;
   logic            o_last;
   logic [GW-1:0]   o_grant;

   int n_err;
   int n_chk;

   pipeline_rr_arbiter #(
      .N  (N),
      .DW (DW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_data  (i_data),
      .i_last  (i_last),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_grant (o_grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [DW-1:0] d, input logic l);
      i_data[k*DW +: DW] = d;
      i_last[k]          = l;
   endtask

   initial begin
      n_err   = 0;
      n_chk   = 0;
      rst_n   = 1'b0;
      i_valid = '0;
      i_data  = '0;
      i_last  = '0;
      o_ready = 1'b0;

      // Reset and idle
      #2;
      chk("rst_o_valid", 32'(o_valid), 32'd0);
      chk("rst_o_data",  32'(o_data),  32'd0);
      chk("rst_o_last",  32'(o_last),  32'd0);
      chk("rst_o_grant", 32'(o_grant), 32'd0);
      chk("rst_i_ready", 32'(i_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n   = 1'b1;
      o_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step();
         chk("idle_o_valid", 32'(o_valid), 32'd0);
         chk("idle_i_ready", 32'(i_ready), 32'd0);
      end

      // Round-robin with single-beat packets
      for (int k = 0; k < N; k++) set_req(k, DW'(k + 100), 1'b1);
      i_valid = 4'hF;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("rr_i_ready", 32'(i_ready), 32'(4'b0001 << (c % 4)));
         step();
         chk("rr_o_valid", 32'(o_valid), 32'd1);
         chk("rr_o_data",  32'(o_data),  32'(100 + (c % 4)));
         chk("rr_o_grant", 32'(o_grant), 32'(c % 4));
      end
      i_valid = '0;
      step();
      chk("rr_drain_o_valid", 32'(o_valid), 32'd0);

      // Packet lock: req0 three beats while req1 waits (ptr=0)
      set_req(1, 16'h0020, 1'b1);
      i_valid = 4'b0011;
      for (int b = 0; b < 3; b++) begin
         set_req(0, 16'(16'h0010 + b), (b == 2));
         #1;
         chk("lock_i_ready", 32'(i_ready), 32'b0001);
         step();
         chk("lock_o_data",  32'(o_data),  32'(16'h0010 + b));
         chk("lock_o_grant", 32'(o_grant), 32'd0);
         chk("lock_o_last",  32'(o_last),  32'(b == 2));
      end
      i_valid = 4'b0010;
      #1;
      chk("lock_r1_i_ready", 32'(i_ready), 32'b0010);
      step();
      chk("lock_r1_o_data",  32'(o_data),  32'h20);
      chk("lock_r1_o_grant", 32'(o_grant), 32'd1);
      i_valid = '0;
      step();

      // Backpressure (ptr=2)
      set_req(2, 16'h00A5, 1'b1);
      i_valid = 4'b0100;
      step();
      chk("bp_first_o_data", 32'(o_data), 32'hA5);
      o_ready = 1'b0;
      set_req(2, 16'h00A6, 1'b1);
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_i_ready", 32'(i_ready), 32'd0);
         step();
         chk("bp_o_valid", 32'(o_valid), 32'd1);
         chk("bp_o_data",  32'(o_data),  32'hA5);
      end
      o_ready = 1'b1;
      #1;
      chk("bp_resume_i_ready", 32'(i_ready), 32'b0100);
      step();
      chk("bp_next_o_data",  32'(o_data),  32'hA6);
      chk("bp_next_o_valid", 32'(o_valid), 32'd1);
      i_valid = '0;
      step();
      chk("bp_nodup_o_valid", 32'(o_valid), 32'd0);

      // Locked bubble (ptr=3): req0 starts, idles two cycles, then finishes
      set_req(0, 16'h0030, 1'b0);
      i_valid = 4'b0001;
      step();
      chk("bub_start_o_data",  32'(o_data),  32'h30);
      chk("bub_start_o_grant", 32'(o_grant), 32'd0);
      set_req(1, 16'h0040, 1'b1);
      i_valid = 4'b0010;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk("bub_i_ready", 32'(i_ready), 32'd0);
         step();
         chk("bub_o_valid", 32'(o_valid), 32'd0);
      end
      set_req(0, 16'h0031, 1'b1);
      i_valid = 4'b0011;
      #1;
      chk("bub_resume_i_ready", 32'(i_ready), 32'b0001);
      step();
      chk("bub_end_o_data", 32'(o_data), 32'h31);
      chk("bub_end_o_last", 32'(o_last), 32'd1);
      i_valid = 4'b0010;
      #1;
      chk("bub_r1_i_ready", 32'(i_ready), 32'b0010);
      step();
      chk("bub_r1_o_data",  32'(o_data),  32'h40);
      chk("bub_r1_o_grant", 32'(o_grant), 32'd1);
      i_valid = '0;
      step();

      // Asynchronous reset mid-packet (ptr=2): req0 locked, then reset
      set_req(0, 16'h0050, 1'b0);
      i_valid = 4'b0001;
      step();
      chk("ar_pre_o_valid", 32'(o_valid), 32'd1);
      chk("ar_pre_o_data",  32'(o_data),  32'h50);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_o_valid", 32'(o_valid), 32'd0);
      chk("ar_o_data",  32'(o_data),  32'd0);
      chk("ar_o_grant", 32'(o_grant), 32'd0);
      set_req(1, 16'h0060, 1'b1);
      i_valid = 4'b0010;
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("ar_post_o_valid", 32'(o_valid), 32'd1);
      chk("ar_post_o_data",  32'(o_data),  32'h60);
      chk("ar_post_o_grant", 32'(o_grant), 32'd1);
      i_valid = '0;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
